mmio_bus_decoder: RTL and testbench
===================================

// Module: mmio_bus_decoder
// PURPOSE
//   Parametrised memory-mapped request router between the CPU data port and NSLV device/RAM targets.
//   Decodes each request by base/mask region, drives one target select with a latched address and data, and waits for a per-target ack.
//   Returns read data with a valid strobe, and flags an error on an unmapped address or an ack timeout.
//   Successor to the fixed-map memory block: region count, widths, wait states and timeout are generic.
// PARAMETERS
//   AW       32          address width
//   DW       32          data width (multiple of 8)
//   NSLV     4           number of target regions
//   BASE     {NSLV*AW}   packed region bases; slot k = BASE[k*AW +: AW]
//   MASK     {NSLV*AW}   packed region masks; slot k hits when (addr & MASK_k) == BASE_k
//   TIMEOUT  15          max ACCESS cycles before error; 0 = no timeout; width clog2(TIMEOUT+1)
// PORTS
//   clk         in   1          clock; all logic on posedge
//   rst         in   1          reset, synchronous, active-low
//   req_valid   in   1          master request valid
//   req_ready   out  1          decoder can accept (high only in IDLE)
//   req_write   in   1          1 = write, 0 = read
//   req_addr    in   AW         byte address
//   req_wdata   in   DW         write data
//   req_wstrb   in   DW/8       byte enables (write only)
//   resp_valid  out  1          one-cycle response strobe (reads and writes)
//   resp_rdata  out  DW         read data; 0 for writes and errors
//   resp_err    out  1          qualifies resp_valid: unmapped or timeout
//   slv_sel     out  NSLV       one-hot target select, held through ACCESS
//   slv_we      out  1          write qualifier to the selected target
//   slv_addr    out  AW         local offset = req_addr & ~MASK_k
//   slv_wdata   out  DW         latched write data
//   slv_wstrb   out  DW/8       latched strobes; 0 on reads
//   slv_ack     in   NSLV       per-target completion, one cycle
//   slv_rdata   in   NSLV*DW    per-target read data, valid with its ack
// BEHAVIOUR
//   Reset (rst=0 at posedge): state=IDLE; req_ready=1 after reset; all other outputs 0; timeout counter 0.
//   FSM IDLE -> ACCESS -> RESP -> IDLE; also IDLE -> RESP on an unmapped address.
//   IDLE:
//     - req_ready=1; accept on req_valid && req_ready (cycle T).
//     - Decode is combinational on req_addr; the lowest-index hit wins when regions overlap.
//     - On a hit: latch sel/we/addr/wdata/wstrb; state=ACCESS at T+1.
//     - On no hit: state=RESP at T+1 with resp_err=1; no slv_sel is asserted.
//   ACCESS:
//     - req_ready=0; slv_sel[k] and the latched bus stay stable.
//     - On slv_ack[k]: capture slv_rdata[k] (reads), clear sel, state=RESP next cycle.
//     - An ack on a non-selected index is ignored.
//     - Zero-wait target (ack at T+1) gives resp_valid at T+2.
//     - If TIMEOUT!=0 and TIMEOUT cycles pass with no ack: clear sel, state=RESP with resp_err=1 and resp_rdata=0.
//     - An ack in the same cycle as expiry wins: the access completes normally.
//   RESP:
//     - resp_valid=1 for exactly one cycle; req_ready=0; state=IDLE next cycle.
//     - A new request is accepted no earlier than the cycle after resp_valid.
//   Stray acks arriving in IDLE or RESP are ignored.
//   Reset mid-transaction: next state IDLE, sel dropped, no response delivered.
//   resp_rdata and resp_err are held at 0 whenever resp_valid=0.
//   Throughput: 1 transaction per 3 cycles minimum (zero-wait target).
// TESTING
//   - Map NSLV=4, slot0 0x0000_0000/0xFFFF_F000, slot3 0xFFFF_FFF0/0xFFFF_FFF0. Read 0x0000_0010 with ack at T+1 and rdata 0xDEAD_BEEF -> slv_sel=0001, slv_addr=0x10, resp_valid at T+2, rdata=0xDEAD_BEEF, err=0.
//   - Write 0xFFFF_FFF4 with wdata=0x1234 and wstrb=0x3; ack after 5 wait cycles -> slv_sel=1000 for 6 cycles, slv_addr=0x4, resp_valid one cycle, rdata=0, err=0.
//   - Read unmapped 0x8000_0000 -> slv_sel stays 0, resp_valid at T+1 with err=1 and rdata=0.
//   - Never ack, TIMEOUT=15 -> sel high for 15 cycles, then resp_valid err=1. A second run acks at the 15th cycle -> err=0.
//   - Overlapping regions (slots 1 and 2 both hit) -> only slv_sel[1] asserts. Stray slv_ack[2] during ACCESS is ignored.
//   - rst low during ACCESS -> IDLE next cycle, slv_sel=0, no resp_valid; a new request is then served normally.

Source files
------------

// File: rtl/mmio_bus_decoder.sv
// Memory-mapped request router: decodes a CPU request by base/mask region, drives one
// target with a latched bus until it acks (or times out), then returns a one-cycle response.
module mmio_bus_decoder #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int NSLV = 4,
    // Default map sends every address to slot 0; real instances override both.
    parameter logic [NSLV*AW-1:0] BASE = '0,
    parameter logic [NSLV*AW-1:0] MASK = '0,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [AW-1:0]      req_addr,
    input  logic [DW-1:0]      req_wdata,
    input  logic [DW/8-1:0]    req_wstrb,
    output logic               resp_valid,
    output logic [DW-1:0]      resp_rdata,
    output logic               resp_err,
    output logic [NSLV-1:0]    slv_sel,
    output logic               slv_we,
    output logic [AW-1:0]      slv_addr,
    output logic [DW-1:0]      slv_wdata,
    output logic [DW/8-1:0]    slv_wstrb,
    input  logic [NSLV-1:0]    slv_ack,
    input  logic [NSLV*DW-1:0] slv_rdata,
    output logic [1:0]         dbg_state
);

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   sel_idx;
    logic [CW-1:0]   cnt;

    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic [NSLV-1:0] hit_sel;
    logic [AW-1:0]   hit_off;

    assign dbg_state = state;

    // Descending scan so the lowest-index matching region is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_sel = '0;
        hit_off = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if ((req_addr & MASK[k*AW +: AW]) == BASE[k*AW +: AW]) begin
                hit        = 1'b1;
                hit_idx    = IW'(k);
                hit_sel    = '0;
                hit_sel[k] = 1'b1;
                hit_off    = req_addr & ~MASK[k*AW +: AW];
            end
        end
    end

    // Handshake: a request transfers on the posedge where req_valid && req_ready; req_ready
    // is high only in IDLE, so the master holds its request until then. resp_valid is a
    // single-cycle strobe with no back-pressure; resp_rdata/resp_err are zero outside it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            slv_sel    <= '0;
            slv_we     <= 1'b0;
            slv_addr   <= '0;
            slv_wdata  <= '0;
            slv_wstrb  <= '0;
            sel_idx    <= '0;
            cnt        <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (hit) begin
                            state     <= S_ACCESS;
                            slv_sel   <= hit_sel;
                            slv_we    <= req_write;
                            slv_addr  <= hit_off;
                            slv_wdata <= req_wdata;
                            slv_wstrb <= req_write ? req_wstrb : '0;
                            sel_idx   <= hit_idx;
                            cnt       <= '0;
                        end else begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack is checked first so an ack on the expiry cycle still completes.
                    if (slv_ack[sel_idx] || (TIMEOUT != 0 && cnt == TO_LAST)) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        if (slv_ack[sel_idx]) begin
                            resp_rdata <= slv_we ? '0 : slv_rdata[sel_idx*DW +: DW];
                        end else begin
                            resp_err <= 1'b1;
                        end
                        slv_sel   <= '0;
                        slv_we    <= 1'b0;
                        slv_addr  <= '0;
                        slv_wdata <= '0;
                        slv_wstrb <= '0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Self-checking bench for mmio_bus_decoder: vector table plus hand sequences, with a
// response scoreboard fed at request time and drained by a negedge monitor.
module tb_mmio_bus_decoder;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NSLV = 4;
    localparam int TIMEOUT = 15;
    // slot1 (0x0001_8000/4K) lies inside slot2 (0x0001_0000/64K), so 0x0001_8xxx hits both.
    localparam logic [NSLV*AW-1:0] BASE = {32'hFFFF_FFF0, 32'h0001_0000, 32'h0001_8000, 32'h0000_0000};
    localparam logic [NSLV*AW-1:0] MASK = {32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000};

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [AW-1:0]      req_addr;
    logic [DW-1:0]      req_wdata;
    logic [DW/8-1:0]    req_wstrb;
    logic               resp_valid;
    logic [DW-1:0]      resp_rdata;
    logic               resp_err;
    logic [NSLV-1:0]    slv_sel;
    logic               slv_we;
    logic [AW-1:0]      slv_addr;
    logic [DW-1:0]      slv_wdata;
    logic [DW/8-1:0]    slv_wstrb;
    logic [NSLV-1:0]    slv_ack;
    logic [NSLV*DW-1:0] slv_rdata;
    logic [1:0]         dbg_state;

    mmio_bus_decoder #(
        .AW(AW), .DW(DW), .NSLV(NSLV), .BASE(BASE), .MASK(MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
        .slv_ack(slv_ack), .slv_rdata(slv_rdata), .dbg_state(dbg_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    logic [DW:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each response must match the oldest expected {err, rdata}.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got err=%0b rdata=0x%0h with nothing expected",
                             resp_err, resp_rdata);
                end else begin
                    check("resp", 64'({resp_err, resp_rdata}), 64'(exp_q.pop_front()));
                end
            end else begin
                check("resp_idle_zero", 64'({resp_err, resp_rdata}), 64'd0);
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ack_dly;     // wait cycles before ack; -1 = never
        logic [3:0]  stray;       // extra acks pulsed in the first ACCESS cycle
        logic [31:0] rdata;
        logic [3:0]  exp_sel;
        logic [31:0] exp_saddr;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_sel_cyc;
        int          exp_lat;     // cycles from accept edge to resp_valid
    } vec_t;

    vec_t vecs[8];

    // Driver: issue one request, play the target side, check the bus every cycle.
    task automatic run_vec(input vec_t v, input string tag);
        int idx = 0;
        int sel_cyc = 0;
        int lat = 0;
        for (int k = 0; k < NSLV; k++) if (v.exp_sel[k]) idx = k;
        for (int k = 0; k < NSLV; k++)
            slv_rdata[k*DW +: DW] = (k == idx) ? v.rdata : (32'hBAD0_0000 | 32'(k));
        @(negedge clk);
        check({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        exp_q.push_back({v.exp_err, v.exp_rdata});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            slv_ack = '0;
            if (resp_valid) begin
                lat = c;
                check({tag, "_ready_in_resp"}, 64'(req_ready), 64'd0);
                check({tag, "_sel_in_resp"}, 64'(slv_sel), 64'd0);
            end else begin
                if (slv_sel != '0) begin
                    sel_cyc++;
                    check({tag, "_sel"}, 64'(slv_sel), 64'(v.exp_sel));
                    check({tag, "_saddr"}, 64'(slv_addr), 64'(v.exp_saddr));
                    check({tag, "_we"}, 64'(slv_we), 64'(v.wr));
                    check({tag, "_wstrb"}, 64'(slv_wstrb), 64'(v.wr ? v.wstrb : 4'h0));
                    if (v.wr) check({tag, "_wdata"}, 64'(slv_wdata), 64'(v.wdata));
                end
                if (v.ack_dly >= 0 && c == v.ack_dly + 1) slv_ack[idx] = 1'b1;
                if (c == 1) slv_ack = slv_ack | v.stray;
            end
        end
        slv_ack = '0;
        check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_sel_cycles"}, 64'(sel_cyc), 64'(v.exp_sel_cyc));
        @(negedge clk);
        check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
        check({tag, "_resp_one_cycle"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        vec_t rv;
        int off;
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 4'h0, 32'hDEAD_BEEF,
                    4'b0001, 32'h10, 1'b0, 32'hDEAD_BEEF, 1, 2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF4, 32'h1234, 4'h3, 5, 4'h0, 32'hCAFE_F00D,
                    4'b1000, 32'h4, 1'b0, 32'h0, 6, 7};
        vecs[2] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, -1, 4'h0, 32'h0,
                    4'b0000, 32'h0, 1'b1, 32'h0, 0, 1};
        vecs[3] = '{1'b0, 32'h0000_0FFC, 32'h0, 4'h0, -1, 4'h0, 32'h7777_7777,
                    4'b0001, 32'hFFC, 1'b1, 32'h0, 15, 16};
        vecs[4] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 14, 4'h0, 32'h5555_AAAA,
                    4'b0001, 32'h20, 1'b0, 32'h5555_AAAA, 15, 16};
        vecs[5] = '{1'b0, 32'h0001_8010, 32'h0, 4'h0, 3, 4'b0100, 32'h1111_2222,
                    4'b0010, 32'h10, 1'b0, 32'h1111_2222, 4, 5};
        vecs[6] = '{1'b1, 32'h0001_0040, 32'hA5A5_5A5A, 4'hF, 0, 4'h0, 32'h9999_0000,
                    4'b0100, 32'h40, 1'b0, 32'h0, 1, 2};
        vecs[7] = '{1'b1, 32'h0000_1000, 32'h55, 4'h1, -1, 4'h0, 32'h0,
                    4'b0000, 32'h0, 1'b1, 32'h0, 0, 1};

        // Reset
        rst = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        slv_ack = '0;
        slv_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp", 64'({resp_err, resp_rdata}), 64'd0);
        check("rst_sel", 64'(slv_sel), 64'd0);
        check("rst_bus", 64'({slv_we, slv_wstrb, slv_addr}), 64'd0);
        check("rst_wdata", 64'(slv_wdata), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stray acks while idle must not start anything.
        @(negedge clk);
        slv_ack = 4'hF;
        repeat (2) begin
            @(negedge clk);
            check("stray_idle_ready", 64'(req_ready), 64'd1);
            check("stray_idle_state", 64'(dbg_state), 64'd0);
        end
        slv_ack = '0;

        // Reset during ACCESS: bus drops, no response is ever delivered.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = '0;
        repeat (3) @(negedge clk);
        check("midrst_sel_before", 64'(slv_sel), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_sel", 64'(slv_sel), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd1);
        check("midrst_state", 64'(dbg_state), 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_vec(vecs[0], "after_rst");

        // Random reads into slot 0 with random wait states.
        for (int i = 0; i < 6; i++) begin
            off = $urandom_range(0, 4095) & ~3;
            rv = '{1'b0, 32'(off), 32'h0, 4'h0, 0, 4'h0, $urandom,
                   4'b0001, 32'(off), 1'b0, 32'h0, 0, 0};
            rv.ack_dly = $urandom_range(0, 4);
            rv.exp_rdata = rv.rdata;
            rv.exp_sel_cyc = rv.ack_dly + 1;
            rv.exp_lat = rv.ack_dly + 2;
            run_vec(rv, $sformatf("rand%0d", i));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
